// File: rtl/series_adder_word_packer.sv
// series_adder_word_packer: collects M serial words into one packed operand vector, hands it to a series adder, and captures the sum
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   s_data_i, s_vld_i, s_rdy_o        serial word input with valid/ready handshake
//   data_o, data_vld_o, data_rdy_i    packed operands (word k at [W*k +: W]) and one-cycle start pulse to the adder
//   result_i, result_vld_i            sum returned by the adder
//   res_o, res_vld_o                  captured sum and its one-cycle update pulse
//   busy_o, err_o                     not-filling indicator, sticky protocol-error flag
module series_adder_word_packer #(
    parameter int M  = 8,
    parameter int W  = 32,
    parameter int RW = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  s_data_i,
    input  logic          s_vld_i,
    output logic          s_rdy_o,
    output logic [M*W-1:0] data_o,
    output logic          data_vld_o,
    input  logic          data_rdy_i,
    input  logic [RW-1:0] result_i,
    input  logic          result_vld_i,
    output logic [RW-1:0] res_o,
    output logic          res_vld_o,
    output logic          busy_o,
    output logic          err_o
);
    localparam int CW = $clog2(M);

    typedef enum logic [1:0] {FILL, ISSUE, WAIT_RES} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic          acc, last, cap;

    assign s_rdy_o = state == FILL;
    assign busy_o  = state != FILL;
    assign acc     = s_rdy_o && s_vld_i;
    assign last    = cnt == CW'(M - 1);
    // a result arriving during the start-pulse cycle is stale and is dropped
    assign cap     = state == WAIT_RES && result_vld_i && !data_vld_o;

    always_comb begin
        nxt = state;
        case (state)
            FILL:     nxt = acc && last ? ISSUE : FILL;
            ISSUE:    nxt = data_rdy_i ? WAIT_RES : ISSUE;
            WAIT_RES: nxt = cap ? FILL : WAIT_RES;
            default:  nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            cnt        <= '0;
            data_o     <= '0;
            data_vld_o <= 1'b0;
            res_o      <= '0;
            res_vld_o  <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state      <= nxt;
            data_vld_o <= state == ISSUE && data_rdy_i;
            res_vld_o  <= cap;
            if (cap)
                res_o <= result_i;
            if (result_vld_i && state != WAIT_RES)
                err_o <= 1'b1;
            if (acc) begin
                data_o[cnt*W +: W] <= s_data_i;
                cnt                <= last ? '0 : cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_series_adder_word_packer.sv
// tb_series_adder_word_packer: directed self-checking bench for series_adder_word_packer
module tb_series_adder_word_packer;
    localparam int M  = 8;
    localparam int W  = 32;
    localparam int RW = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  s_data_i = '0;
    logic          s_vld_i = 1'b0;
    logic          s_rdy_o;
    logic [M*W-1:0] data_o;
    logic          data_vld_o;
    logic          data_rdy_i = 1'b0;
    logic [RW-1:0] result_i = '0;
    logic          result_vld_i = 1'b0;
    logic [RW-1:0] res_o;
    logic          res_vld_o;
    logic          busy_o;
    logic          err_o;
    int            total = 0;
    int            bad = 0;

    series_adder_word_packer #(.M(M), .W(W), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .s_data_i(s_data_i), .s_vld_i(s_vld_i), .s_rdy_o(s_rdy_o),
        .data_o(data_o), .data_vld_o(data_vld_o), .data_rdy_i(data_rdy_i),
        .result_i(result_i), .result_vld_i(result_vld_i), .res_o(res_o), .res_vld_o(res_vld_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"}, s_rdy_o, 1);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_data"}, data_o, 0);
        chk({tag, "_dvld"}, data_vld_o, 0);
        chk({tag, "_res"}, res_o, 0);
        chk({tag, "_rvld"}, res_vld_o, 0);
        chk({tag, "_err"}, err_o, 0);
    endtask

    task automatic send(input int v, input bit gap);
        chk($sformatf("rdy_before_%0d", v), s_rdy_o, 1);
        s_data_i = W'(v);
        s_vld_i  = 1'b1;
        step();
        s_vld_i  = 1'b0;
        if (gap) step();
    endtask

    task automatic fill(input int base, input int lo, input int hi, input bit gap);
        for (int i = lo; i <= hi; i++) send(base + i, gap && i != hi);
    endtask

    task automatic chk_words(input int base);
        chk("issue_rdy", s_rdy_o, 0);
        chk("issue_busy", busy_o, 1);
        chk("issue_dvld", data_vld_o, 0);
        for (int k = 0; k < M; k++) chk($sformatf("word%0d", k), data_o[k*W +: W], W'(base + k));
    endtask

    task automatic issue(input int d);
        data_rdy_i = 1'b0;
        for (int i = 0; i < d; i++) begin
            step();
            chk("bp_dvld", data_vld_o, 0);
            chk("bp_rdy", s_rdy_o, 0);
        end
        data_rdy_i = 1'b1;
        step();
        chk("pulse_on", data_vld_o, 1);
        chk("pulse_busy", busy_o, 1);
    endtask

    task automatic finish(input int res);
        step();
        chk("pulse_off", data_vld_o, 0);
        chk("wait_busy", busy_o, 1);
        result_i     = RW'(res);
        result_vld_i = 1'b1;
        step();
        result_vld_i = 1'b0;
        chk("res", res_o, RW'(res));
        chk("res_vld_on", res_vld_o, 1);
        chk("fill_rdy", s_rdy_o, 1);
        chk("fill_busy", busy_o, 0);
        step();
        chk("res_vld_off", res_vld_o, 0);
        chk("res_hold", res_o, RW'(res));
    endtask

    initial begin
        #12;
        chk_reset("rst0");
        step();
        rst_n = 1'b1;
        step();
        // back-to-back words 1..8
        data_rdy_i = 1'b1;
        fill(1, 0, 7, 0);
        chk_words(1);
        issue(0);
        finish(36);
        // alternate-cycle gaps
        fill(1, 0, 7, 1);
        chk_words(1);
        issue(0);
        finish(36);
        // backpressure for 5 cycles
        fill(1, 0, 7, 0);
        chk_words(1);
        issue(5);
        finish(36);
        chk("err_clean", err_o, 0);
        // stray result after 3 words
        fill(1, 0, 2, 0);
        result_i     = RW'(77);
        result_vld_i = 1'b1;
        step();
        result_vld_i = 1'b0;
        chk("stray_err", err_o, 1);
        chk("stray_rvld", res_vld_o, 0);
        chk("stray_res", res_o, 36);
        chk("stray_rdy", s_rdy_o, 1);
        fill(1, 3, 7, 0);
        chk_words(1);
        issue(0);
        finish(36);
        chk("err_sticky", err_o, 1);
        // reset in WAIT_RES
        fill(1, 0, 7, 0);
        issue(0);
        step();
        chk("pre_rst_busy", busy_o, 1);
        rst_n = 1'b0;
        #2;
        chk_reset("rst1");
        step();
        rst_n = 1'b1;
        step();
        chk_reset("post_rst");
        fill(10, 0, 7, 0);
        chk_words(10);
        issue(0);
        finish(108);
        // result coincident with the start pulse is ignored
        fill(20, 0, 7, 0);
        chk_words(20);
        issue(0);
        result_i     = RW'(99);
        result_vld_i = 1'b1;
        step();
        result_vld_i = 1'b0;
        chk("pc_rvld", res_vld_o, 0);
        chk("pc_err", err_o, 0);
        chk("pc_busy", busy_o, 1);
        chk("pc_res", res_o, 108);
        finish(188);
        chk("err_end", err_o, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
